// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses imem and loads the IF/ID register.
// One-cycle fetch latency; a stall holds everything, and a taken branch flushes IF/ID even while stalled.
module pc_fetch_unit #(
   parameter logic [15:0] PC_RESET    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] redirect_pc,
   input  logic [15:0] imem_data,
   output logic [15:0] pc,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        halted
);

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] instr_q;
   logic [15:0] pc_plus2_q;
   logic        valid_q;

   logic [15:0] pc_plus2_d;
   logic        is_halt;

   assign pc_plus2_d = pc_q + 16'h0002;
   assign is_halt    = (imem_data[15:12] == HALT_OPCODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= PC_RESET;
         instr_q    <= 16'h0000;
         pc_plus2_q <= 16'h0000;
         valid_q    <= 1'b0;
         state_q    <= FETCH;
      end else if (branch_taken) begin
         // Redirect wins over stall and cancels any HLT fetched in the branch shadow.
         pc_q    <= redirect_pc;
         instr_q <= 16'h0000;
         valid_q <= 1'b0;
         state_q <= FETCH;
      end else if (!stall) begin
         if (state_q == HALTED) begin
            valid_q <= 1'b0;
         end else begin
            instr_q    <= imem_data;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= 1'b1;
            if (is_halt) begin
               state_q <= HALTED;
            end else begin
               pc_q <= pc_plus2_d;
            end
         end
      end
   end

   assign pc            = pc_q;
   assign ifid_instr    = instr_q;
   assign ifid_pc_plus2 = pc_plus2_q;
   assign ifid_valid    = valid_q;
   assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the fetch stage.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [15:0] redirect_pc;
   logic [15:0] imem_data;
   logic [15:0] pc;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        ifid_valid;
   logic        halted;

   logic [15:0] mem [256];
   logic        use_force;
   logic [15:0] force_val;
   logic        chk_en;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [15:0] m_pc, m_instr, m_p2;
   logic        m_valid, m_halt;

   always #5 clk = ~clk;

   function automatic logic [15:0] imem_at(input logic [15:0] a);
      return use_force ? force_val : mem[a[8:1]];
   endfunction

   assign imem_data = imem_at(pc);

   pc_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .redirect_pc   (redirect_pc),
      .imem_data     (imem_data),
      .pc            (pc),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .ifid_valid    (ifid_valid),
      .halted        (halted)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one fetch step per edge, written from the stage's rules.
   always @(posedge clk or negedge rst_n) begin
      logic [15:0] word;
      if (!rst_n) begin
         m_pc = 16'h0000; m_instr = 16'h0000; m_p2 = 16'h0000;
         m_valid = 1'b0;  m_halt = 1'b0;
      end else begin
         word = imem_at(m_pc);
         if (branch_taken) begin
            m_pc = redirect_pc; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
         end else if (stall) begin
            // nothing moves
         end else if (m_halt) begin
            m_valid = 1'b0;
         end else begin
            m_instr = word;
            m_p2    = m_pc + 16'd2;
            m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_halt = 1'b1;
            else                     m_pc   = m_pc + 16'd2;
         end
      end
   end

   // Compare process: outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", pc, m_pc);
         chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
         chk("halted", {15'd0, halted}, {15'd0, m_halt});
         chk("ifid_instr", ifid_instr, m_instr);
         chk("ifid_pc_plus2", ifid_pc_plus2, m_p2);
         // a valid IF/ID entry must be the memory word at (pc_plus2 - 2)
         if (!use_force && ifid_valid)
            chk("ifid_matches_mem", ifid_instr, mem[(ifid_pc_plus2 - 16'd2) >> 1 & 16'h00FF]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      use_force = 1'b1; force_val = 16'h1234;
      stall = 1'b0; branch_taken = 1'b0; redirect_pc = 16'h0000;
      chk_en = 1'b0;
      rst_n = 1'b0;
      #12;
      // reset state
      chk("rst_pc", pc, 16'h0000);
      chk("rst_valid", {15'd0, ifid_valid}, 16'h0000);
      chk("rst_halted", {15'd0, halted}, 16'h0000);
      chk("rst_instr", ifid_instr, 16'h0000);
      chk("rst_p2", ifid_pc_plus2, 16'h0000);
      chk_en = 1'b1;
      tick(); rst_n = 1'b1;

      // sequential fetch of 1234
      tick(); chk("seq_pc0", pc, 16'h0002); chk("seq_p2_0", ifid_pc_plus2, 16'h0002);
      chk("seq_instr", ifid_instr, 16'h1234); chk("seq_valid", {15'd0, ifid_valid}, 16'h0001);
      tick(); chk("seq_pc1", pc, 16'h0004); chk("seq_p2_1", ifid_pc_plus2, 16'h0004);
      tick(); chk("seq_pc2", pc, 16'h0006);

      // stall for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("stall_pc", pc, 16'h0006); chk("stall_p2", ifid_pc_plus2, 16'h0006);
      end
      stall = 1'b0;
      tick(); chk("unstall_pc", pc, 16'h0008);

      // branch while stalled
      stall = 1'b1; branch_taken = 1'b1; redirect_pc = 16'h0040;
      tick(); chk("br_pc", pc, 16'h0040); chk("br_valid", {15'd0, ifid_valid}, 16'h0000);
      chk("br_instr", ifid_instr, 16'h0000);
      stall = 1'b0; branch_taken = 1'b0;
      tick(); chk("br_fetch_pc", pc, 16'h0042); chk("br_fetch_p2", ifid_pc_plus2, 16'h0042);

      // HLT at 0010
      branch_taken = 1'b1; redirect_pc = 16'h0010;
      tick(); branch_taken = 1'b0; force_val = 16'hF000;
      tick(); chk("hlt_instr", ifid_instr, 16'hF000); chk("hlt_valid", {15'd0, ifid_valid}, 16'h0001);
      chk("hlt_pc", pc, 16'h0010); chk("hlt_halted", {15'd0, halted}, 16'h0001);
      force_val = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         tick(); chk("halt_bubble", {15'd0, ifid_valid}, 16'h0000); chk("halt_pc", pc, 16'h0010);
      end

      // leave HALTED by branch
      branch_taken = 1'b1; redirect_pc = 16'h0100;
      tick(); chk("exit_halted", {15'd0, halted}, 16'h0000); chk("exit_pc", pc, 16'h0100);
      branch_taken = 1'b0;
      tick(); chk("resume_pc", pc, 16'h0102); chk("resume_valid", {15'd0, ifid_valid}, 16'h0001);

      // wrap at FFFE
      branch_taken = 1'b1; redirect_pc = 16'hFFFE;
      tick(); branch_taken = 1'b0;
      tick(); chk("wrap_pc", pc, 16'h0000); chk("wrap_p2", ifid_pc_plus2, 16'h0000);

      // asynchronous reset mid-cycle
      tick(); #2; rst_n = 1'b0; #1;
      chk("arst_pc", pc, 16'h0000); chk("arst_valid", {15'd0, ifid_valid}, 16'h0000);
      #3; rst_n = 1'b1;

      // randomized traffic from the random memory image
      use_force = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         stall        = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 11) == 0);
         redirect_pc  = ($urandom_range(0, 15) == 0) ? 16'hFFFE : {7'd0, 8'($urandom), 1'b0};
         if ($urandom_range(0, 999) == 0) begin
            #2; rst_n = 1'b0; #2; rst_n = 1'b1;
         end
      end
      tick();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
